// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the write master, the matching slave side
// and the bench's state-name decoder.
//   wr_state_e     : write-master FSM states (2-bit, value 3 unused)
//   RESP_*         : BRESP/RRESP codes
//   AXPROT_DEFAULT : unprivileged, secure, data access
package axil_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_RESP  = 2'd2
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXPROT_DEFAULT = 3'b000;

    // Any response other than OKAY counts as an error for the sticky flag.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_wr_master.sv
// AXI4-Lite write initiator: one AXI write per accepted command.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   cmd_valid/ready/addr/data/strb: command port (valid/ready)
//   done_valid, done_resp         : one-cycle completion pulse with BRESP
//   err_sticky, err_clr           : sticky non-OKAY flag and its clear
//   wr_count                      : completed-write counter (wraps)
//   m_axi_aw*, m_axi_w*, m_axi_b* : AXI4-Lite write channels
// DATA_WIDTH is expected to be 32 or 64.
module axil_wr_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_data,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
    output logic                      done_valid,
    output logic [1:0]                done_resp,
    output logic                      err_sticky,
    input  logic                      err_clr,
    output logic [CNT_WIDTH-1:0]      wr_count,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);

    wr_state_e                 state_q, state_d;
    logic                      init_q;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      bready_q, bready_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                      done_valid_q, done_valid_d;
    logic [1:0]                done_resp_q, done_resp_d;
    logic                      err_q, err_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

    logic aw_hs;
    logic w_hs;
    logic aw_complete;
    logic w_complete;

    // init_q holds cmd_ready low until the first clock after reset release.
    assign cmd_ready = init_q && (state_q == S_IDLE);

    assign aw_hs       = awvalid_q && m_axi_awready;
    assign w_hs        = wvalid_q && m_axi_wready;
    // A channel counts as complete if it finished earlier or finishes now.
    assign aw_complete = aw_done_q || aw_hs;
    assign w_complete  = w_done_q || w_hs;

    always_comb begin
        state_d      = state_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        done_valid_d = 1'b0;
        done_resp_d  = done_resp_q;
        cnt_d        = cnt_q;
        err_d        = err_q;

        // Clear first so a same-cycle error response below overrides it.
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    awaddr_d  = cmd_addr;
                    wdata_d   = cmd_data;
                    wstrb_d   = cmd_strb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_complete && w_complete) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d     = 1'b0;
                    done_valid_d = 1'b1;
                    done_resp_d  = m_axi_bresp;
                    cnt_d        = cnt_q + CNT_WIDTH'(1);
                    if (resp_is_error(m_axi_bresp)) begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                // Unused encoding: drop every handshake and recover.
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            init_q       <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            done_valid_q <= 1'b0;
            done_resp_q  <= 2'b00;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            init_q       <= 1'b1;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            done_valid_q <= done_valid_d;
            done_resp_q  <= done_resp_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign done_valid    = done_valid_q;
    assign done_resp     = done_resp_q;
    assign err_sticky    = err_q;
    assign wr_count      = cnt_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = AXPROT_DEFAULT;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axil_wr_master.sv
// Self-checking bench for axil_wr_master. A small counter is used so the
// wr_count wrap is reached in a few hundred writes.
module tb_axil_wr_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [SW-1:0] cmd_strb;
    logic          done_valid;
    logic [1:0]    done_resp;
    logic          err_sticky;
    logic          err_clr;
    logic [CW-1:0] wr_count;
    logic [AW-1:0] m_axi_awaddr;
    logic [2:0]    m_axi_awprot;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;

    axil_wr_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_strb     (cmd_strb),
        .done_valid   (done_valid),
        .done_resp    (done_resp),
        .err_sticky   (err_sticky),
        .err_clr      (err_clr),
        .wr_count     (wr_count),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awprot (m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: completed-write count and sticky error flag.
    int exp_cnt = 0;
    bit exp_err = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Runs one write from a negedge where the DUT is expected idle. The slave
    // raises awready after aw_dly cycles, wready after w_dly cycles and bvalid
    // b_dly cycles after bready. Unused inputs carry noise that must be ignored.
    // Returns on the negedge of the done_valid cycle so the next call can
    // present its command in that same cycle.
    task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input int aw_dly,
                             input int w_dly, input int b_dly,
                             input logic [1:0] resp, input bit clr_with_b);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit fin     = 1'b0;
        bit b_hs;
        int bw = 0;
        check_val("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_strb  = s;
        err_clr   = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 100 && !fin; c++) begin
            cmd_valid = 1'($urandom);
            cmd_addr  = AW'($urandom);
            cmd_data  = $urandom;
            cmd_strb  = SW'($urandom);
            check_val("cmd_ready_busy", 64'(cmd_ready), 64'd0);
            check_val("done_quiet", 64'(done_valid), 64'd0);
            check_val("awvalid", 64'(m_axi_awvalid), 64'(!aw_done));
            check_val("wvalid", 64'(m_axi_wvalid), 64'(!w_done));
            check_val("bready", 64'(m_axi_bready), 64'(aw_done && w_done));
            if (!aw_done) check_val("awaddr", 64'(m_axi_awaddr), 64'(a));
            if (!w_done) begin
                check_val("wdata", 64'(m_axi_wdata), 64'(d));
                check_val("wstrb", 64'(m_axi_wstrb), 64'(s));
            end
            m_axi_awready = aw_done ? 1'($urandom) : (c >= aw_dly);
            m_axi_wready  = w_done ? 1'($urandom) : (c >= w_dly);
            if (aw_done && w_done) begin
                m_axi_bvalid = (bw >= b_dly);
                m_axi_bresp  = m_axi_bvalid ? resp : 2'($urandom);
                err_clr      = m_axi_bvalid && clr_with_b;
                bw++;
            end else begin
                m_axi_bvalid = 1'($urandom);
                m_axi_bresp  = 2'b10;
                err_clr      = 1'b0;
            end
            b_hs = aw_done && w_done && m_axi_bvalid;
            if (!aw_done && m_axi_awready) aw_done = 1'b1;
            if (!w_done && m_axi_wready) w_done = 1'b1;
            @(negedge clk);
            if (b_hs) begin
                fin = 1'b1;
                exp_cnt = (exp_cnt + 1) % (1 << CW);
                if (resp != 2'b00) exp_err = 1'b1;
                else if (clr_with_b) exp_err = 1'b0;
                check_val("done_valid", 64'(done_valid), 64'd1);
                check_val("done_resp", 64'(done_resp), 64'(resp));
                check_val("wr_count", 64'(wr_count), 64'(exp_cnt));
                check_val("err_sticky", 64'(err_sticky), 64'(exp_err));
                check_val("bready_low", 64'(m_axi_bready), 64'd0);
                check_val("valids_low", 64'({m_axi_awvalid, m_axi_wvalid}), 64'd0);
            end
        end
        check_val("txn_done", 64'(fin), 64'd1);
        cmd_valid     = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        err_clr       = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_addr      = '0;
        cmd_data      = '0;
        cmd_strb      = '0;
        err_clr       = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_bvalid  = 1'b0;

        // Reset state.
        @(negedge clk);
        check_val("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_val("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
        check_val("rst_done", 64'({done_valid, done_resp}), 64'd0);
        check_val("rst_err", 64'(err_sticky), 64'd0);
        check_val("rst_count", 64'(wr_count), 64'd0);
        check_val("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
        check_val("rst_wdata", 64'(m_axi_wdata), 64'd0);
        check_val("rst_wstrb", 64'(m_axi_wstrb), 64'd0);
        check_val("awprot", 64'(m_axi_awprot), 64'd0);
        rst = 1'b0;
        #1;
        check_val("rdy_before_clk", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check_val("rdy_after_clk", 64'(cmd_ready), 64'd1);

        // Single write, slave always ready.
        run_write(12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 1'b0);
        @(negedge clk);

        // Delayed address, then delayed data.
        run_write(12'h024, 32'h12345678, 4'h3, 5, 0, 1, 2'b00, 1'b0);
        @(negedge clk);
        run_write(12'h024, 32'h12345678, 4'h3, 0, 5, 1, 2'b00, 1'b0);
        @(negedge clk);

        // Back-to-back: each command presented in the predecessor's done cycle.
        for (int i = 0; i < 4; i++) begin
            run_write(AW'(12'h100 + 4 * i), 32'hA5A50000 + 32'(i), 4'hF, 0, 0, 0, 2'b00, 1'b0);
        end
        @(negedge clk);

        // Error flag: set, set-wins-over-clear, then clear alone.
        run_write(12'h040, 32'h0BAD0BAD, 4'hF, 1, 2, 0, 2'b10, 1'b0);
        @(negedge clk);
        run_write(12'h044, 32'h0BAD0BAE, 4'hC, 0, 0, 2, 2'b10, 1'b1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
        check_val("err_clr_alone", 64'(err_sticky), 64'(exp_err));

        // Reset while the address channel is still pending.
        cmd_valid = 1'b1;
        cmd_addr  = 12'h0F0;
        cmd_data  = 32'hCAFEF00D;
        cmd_strb  = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_val("pre_rst_awvalid", 64'(m_axi_awvalid), 64'd1);
        rst = 1'b1;
        #1;
        check_val("rst_async_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
        check_val("rst_async_done", 64'(done_valid), 64'd0);
        check_val("rst_async_rdy", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        exp_err = 1'b0;
        @(negedge clk);
        check_val("post_rst_done", 64'(done_valid), 64'd0);
        check_val("post_rst_count", 64'(wr_count), 64'd0);
        run_write(12'h0F0, 32'hCAFEF00D, 4'hF, 0, 0, 0, 2'b00, 1'b0);

        // Random traffic long enough to wrap the counter.
        for (int t = 0; t < 300; t++) begin
            logic [1:0] r;
            r = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            run_write(AW'($urandom), $urandom, SW'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 2), r, 1'($urandom_range(0, 3) == 0));
            if (exp_cnt == 0) check_val("wrap", 64'(wr_count), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
